// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Runs one ALU operation at a time: accept request, read operands from the
//   register file, drive the combinational ALU, write back the result and
//   latch the ALU flags into the PSR.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready          request handshake
//   req_opcode/rdest/rsrc/imm    request fields; req_use_imm selects imm as B
//   rf_rd_addr_a/b, rf_rd_data_a/b   register-file read ports
//   rf_we, rf_wr_addr, rf_wr_data    register-file write port
//   alu_a/b/opcode/cin, alu_c/flags  ALU drive and combinational result
//   psr                          latched flags, ordered Z C F N L
//   busy, done                   op in flight / one-cycle completion pulse
module alu_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int FLAG_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_opcode,
  input  logic [REG_AW-1:0] req_rdest,
  input  logic [REG_AW-1:0] req_rsrc,
  input  logic [7:0]        req_imm,
  input  logic              req_use_imm,
  output logic [REG_AW-1:0] rf_rd_addr_a,
  output logic [REG_AW-1:0] rf_rd_addr_b,
  input  logic [DATA_W-1:0] rf_rd_data_a,
  input  logic [DATA_W-1:0] rf_rd_data_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [FLAG_W-1:0] psr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t              state;
  logic [7:0]          op_p0;
  logic [REG_AW-1:0]   rdest_p0;
  logic [7:0]          imm_p0;
  logic                use_imm_p0;
  logic [FLAG_W-1:0]   flags_p2;
  logic                upd_psr_p2;
  logic                accept;

  // Signed immediate forms are ADDI, ADDCI, SUBI, CMPI; everything else
  // (ADDUI included) zero-extends.
  function automatic logic [DATA_W-1:0] ext_imm(input logic [7:0] op,
                                                 input logic [7:0] imm);
    logic sx;
    sx = (op[7:4] == 4'b0101) || (op[7:4] == 4'b0111) ||
         (op[7:4] == 4'b1001) || (op[7:4] == 4'b1011);
    return {{(DATA_W-8){sx & imm[7]}}, imm};
  endfunction

  // Compares and NOP never write the destination register.
  function automatic logic writes_back(input logic [7:0] op);
    return !((op == 8'h00) || (op == 8'h0B) || (op == 8'h0F) ||
             (op[7:4] == 4'b1011));
  endfunction

  assign req_ready = (state == IDLE) || (state == WB);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      op_p0        <= '0;
      rdest_p0     <= '0;
      imm_p0       <= '0;
      use_imm_p0   <= 1'b0;
      flags_p2     <= '0;
      upd_psr_p2   <= 1'b0;
      rf_rd_addr_a <= '0;
      rf_rd_addr_b <= '0;
      rf_we        <= 1'b0;
      rf_wr_addr   <= '0;
      rf_wr_data   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      alu_cin      <= 1'b0;
      psr          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      done  <= 1'b0;

      // Stage p0: request capture (IDLE or WB), read addresses launched
      if (accept) begin
        op_p0        <= req_opcode;
        rdest_p0     <= req_rdest;
        imm_p0       <= req_imm;
        use_imm_p0   <= req_use_imm;
        rf_rd_addr_a <= req_rdest;
        rf_rd_addr_b <= req_rsrc;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state <= READ;
            busy  <= 1'b1;
          end
        end
        // Stage p1: operands registered onto the ALU inputs
        READ: begin
          alu_a      <= rf_rd_data_a;
          alu_b      <= use_imm_p0 ? ext_imm(op_p0, imm_p0) : rf_rd_data_b;
          alu_opcode <= op_p0;
          alu_cin    <= psr[3];
          state      <= EXEC;
        end
        // Stage p2: ALU result and flags held for write-back
        EXEC: begin
          rf_wr_data <= alu_c;
          rf_wr_addr <= rdest_p0;
          flags_p2   <= alu_flags;
          upd_psr_p2 <= (op_p0 != 8'h00);
          rf_we      <= writes_back(op_p0);
          done       <= 1'b1;
          state      <= WB;
        end
        // Stage p3: write-back cycle; PSR committed at its closing edge
        WB: begin
          if (upd_psr_p2) psr <= flags_p2;
          if (accept) begin
            state <= READ;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_opcode = '0;
  logic [3:0]  req_rdest = '0;
  logic [3:0]  req_rsrc = '0;
  logic [7:0]  req_imm = '0;
  logic        req_use_imm = 1'b0;
  logic [3:0]  rf_rd_addr_a, rf_rd_addr_b;
  logic [15:0] rf_rd_data_a, rf_rd_data_b;
  logic        rf_we;
  logic [3:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic [15:0] alu_a, alu_b;
  logic [7:0]  alu_opcode;
  logic        alu_cin;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        busy, done;

  alu_op_sequencer #(.DATA_W(16), .REG_AW(4), .FLAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_rdest(req_rdest), .req_rsrc(req_rsrc),
    .req_imm(req_imm), .req_use_imm(req_use_imm),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_c(alu_c), .alu_flags(alu_flags),
    .psr(psr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: address registered by the DUT, data follows the address.
  logic [15:0] regs [16];
  logic        tb_we = 1'b0;
  logic [3:0]  tb_waddr = '0;
  logic [15:0] tb_wdata = '0;
  assign rf_rd_data_a = regs[rf_rd_addr_a];
  assign rf_rd_data_b = regs[rf_rd_addr_b];
  always @(posedge clk) begin
    if (rf_we)      regs[rf_wr_addr] <= rf_wr_data;
    else if (tb_we) regs[tb_waddr]   <= tb_wdata;
  end

  // ALU: key is the low nibble for register forms, high nibble otherwise.
  // 5/6 add, 7 add-with-carry, 9 sub, B/F compare. Flags Z C F N L.
  logic [3:0]  alu_key;
  logic [16:0] alu_s;
  always_comb begin
    alu_key   = (alu_opcode[7:4] == 4'h0) ? alu_opcode[3:0] : alu_opcode[7:4];
    alu_s     = '0;
    alu_c     = '0;
    alu_flags = '0;
    case (alu_key)
      4'h5, 4'h6, 4'h7, 4'h9: begin
        if (alu_key == 4'h9)      alu_s = {1'b0, alu_a} - {1'b0, alu_b};
        else if (alu_key == 4'h7) alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_cin};
        else                      alu_s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c        = alu_s[15:0];
        alu_flags[4] = (alu_s[15:0] == 16'h0);
        alu_flags[3] = alu_s[16];
        alu_flags[2] = (alu_key == 4'h9) ?
                       ((alu_a[15] != alu_b[15]) && (alu_s[15] != alu_a[15])) :
                       ((alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]));
        alu_flags[1] = alu_s[15];
      end
      4'hB, 4'hF: begin
        alu_flags[4] = (alu_a == alu_b);
        alu_flags[1] = ($signed(alu_a) < $signed(alu_b));
        alu_flags[0] = (alu_a < alu_b);
      end
      default: ;
    endcase
  end

  typedef struct {
    logic        wb;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [4:0]  psr;
    logic [15:0] b;
    logic        cin;
    int          acc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Drives a request at a negedge and returns just after the accepting edge.
  task automatic send(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [7:0] imm, input logic ui,
                      input logic wb, input logic [15:0] wdata, input logic [4:0] epsr,
                      input logic [15:0] eb, input logic ecin, input bit track);
    int   n;
    exp_t e;
    @(negedge clk);
    req_opcode = op; req_rdest = rd; req_rsrc = rs; req_imm = imm; req_use_imm = ui;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got=ready0 expected=ready1 (cycle %0d)", cyc);
    end else if (track) begin
      e.wb = wb; e.addr = rd; e.data = wdata; e.psr = epsr;
      e.b = eb; e.cin = ecin; e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  // Drop valid and scramble the request fields; they must not matter now.
  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0; req_opcode = 8'hFF; req_rdest = 4'hF; req_rsrc = 4'hE;
    req_imm = 8'h55; req_use_imm = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rf_we && !done) begin
        checks++; errors++;
        $display("FAIL stray_we got=we1 expected=we0 (cycle %0d)", cyc);
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done got=done1 expected=done0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("latency", 16'(cyc - e.acc), 16'd3);
          chk("rf_we", 16'(rf_we), 16'(e.wb));
          if (e.wb) begin
            chk("wr_addr", 16'(rf_wr_addr), 16'(e.addr));
            chk("wr_data", rf_wr_data, e.data);
          end
          chk("alu_b", alu_b, e.b);
          chk("alu_cin", 16'(alu_cin), 16'(e.cin));
          @(negedge clk);
          chk("psr", 16'(psr), 16'(e.psr));
        end
      end
    end
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_psr", 16'(psr), 16'h0);
    chk("rst_we", 16'(rf_we), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_alu_a", alu_a, 16'h0);
    chk("rst_alu_b", alu_b, 16'h0);
    chk("rst_rd_addr_a", 16'(rf_rd_addr_a), 16'h0);
    chk("rst_wr_data", rf_wr_data, 16'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 16'(req_ready), 16'h1);

    poke(4'd1, 16'h0003); poke(4'd2, 16'h0004); poke(4'd3, 16'h0000);
    poke(4'd4, 16'h0000); poke(4'd5, 16'hFFFF); poke(4'd6, 16'h0010);
    poke(4'd7, 16'h0100); poke(4'd8, 16'h0001); poke(4'd9, 16'h0002);

    // ADD r1+r2 = 7
    send(8'h05, 4'd1, 4'd2, 8'h00, 1'b0, 1'b1, 16'h0007, 5'b00000, 16'h0004, 1'b0, 1'b1);
    idle(5);
    // ADD 0xFFFF+1 sets Z,C; then ADDC 0+0 with carry-in = 1
    poke(4'd1, 16'hFFFF); poke(4'd2, 16'h0001);
    send(8'h05, 4'd1, 4'd2, 8'h00, 1'b0, 1'b1, 16'h0000, 5'b11000, 16'h0001, 1'b0, 1'b1);
    idle(3);
    send(8'h07, 4'd3, 4'd4, 8'h00, 1'b0, 1'b1, 16'h0001, 5'b00000, 16'h0000, 1'b1, 1'b1);
    idle(3);
    // CMPI r5 vs sign-extended 0xFF: equal, no write-back
    send(8'hB0, 4'd5, 4'd0, 8'hFF, 1'b1, 1'b0, 16'h0000, 5'b10000, 16'hFFFF, 1'b0, 1'b1);
    idle(3);
    // ADDUI zero-extends, ADDI sign-extends
    send(8'h60, 4'd6, 4'd0, 8'h80, 1'b1, 1'b1, 16'h0090, 5'b00000, 16'h0080, 1'b0, 1'b1);
    idle(3);
    send(8'h50, 4'd7, 4'd0, 8'h80, 1'b1, 1'b1, 16'h0080, 5'b01000, 16'hFF80, 1'b0, 1'b1);
    // Back-to-back chain, each op consuming the previous write-back
    send(8'h05, 4'd8, 4'd9, 8'h00, 1'b0, 1'b1, 16'h0003, 5'b00000, 16'h0002, 1'b1, 1'b1);
    send(8'h05, 4'd8, 4'd8, 8'h00, 1'b0, 1'b1, 16'h0006, 5'b00000, 16'h0003, 1'b0, 1'b1);
    send(8'h09, 4'd9, 4'd8, 8'h00, 1'b0, 1'b1, 16'hFFFC, 5'b01010, 16'h0006, 1'b0, 1'b1);
    send(8'h05, 4'd8, 4'd9, 8'h00, 1'b0, 1'b1, 16'h0002, 5'b01000, 16'hFFFC, 1'b1, 1'b1);
    idle(4);
    // NOP keeps psr; CMP and CMPU update psr only
    send(8'h00, 4'd1, 4'd2, 8'h00, 1'b0, 1'b0, 16'h0000, 5'b01000, 16'h0001, 1'b1, 1'b1);
    idle(3);
    send(8'h0B, 4'd5, 4'd6, 8'h00, 1'b0, 1'b0, 16'h0000, 5'b00010, 16'h0090, 1'b1, 1'b1);
    idle(3);
    send(8'h0F, 4'd6, 4'd5, 8'h00, 1'b0, 1'b0, 16'h0000, 5'b00001, 16'hFFFF, 1'b0, 1'b1);
    idle(3);
    chk("r3_after_addc", regs[3], 16'h0001);
    chk("r5_after_cmp", regs[5], 16'hFFFF);

    // Reset during EXEC aborts the op
    send(8'h05, 4'd1, 4'd2, 8'h00, 1'b0, 1'b0, 16'h0000, 5'b00000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_we", 16'(rf_we), 16'h0);
    chk("abort_psr", 16'(psr), 16'h0);
    chk("abort_busy", 16'(busy), 16'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 16'(req_ready), 16'h1);
    chk("abort_r1", regs[1], 16'h0000);
    send(8'h05, 4'd1, 4'd2, 8'h00, 1'b0, 1'b1, 16'h0001, 5'b00000, 16'h0001, 1'b0, 1'b1);
    idle(3);
    send(8'h05, 4'd5, 4'd5, 8'h00, 1'b0, 1'b1, 16'hFFFE, 5'b01010, 16'hFFFF, 1'b0, 1'b1);
    idle(3);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain got=%0d expected=0 pending", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sequences one ALU operation at a time: accepts an operation request, reads operands from the register file, drives the combinational ALU, writes back the result and latches flags into the processor status register (PSR).
- Sits between the instruction decode stage and the ALU/register-file pair. It is the only agent that drives ALU inputs and register-file write ports.

Parameters:
- DATA_W, 16, ALU and register data width.
- REG_AW, 4, register-file address width (16 registers).
- FLAG_W, 5, flag width, ordered ZCFNL (4=Z, 3=C, 2=F overflow, 1=N, 0=L).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept.
- req_opcode  in  8  ALU opcode (ALU encoding).
- req_rdest  in  REG_AW  destination register, also operand A source.
- req_rsrc  in  REG_AW  operand B source register.
- req_imm  in  8  immediate byte.
- req_use_imm  in  1  B comes from the immediate, not rsrc.
- rf_rd_addr_a  out  REG_AW  register-file read address A.
- rf_rd_addr_b  out  REG_AW  register-file read address B.
- rf_rd_data_a  in  DATA_W  read data A; synchronous read, valid 1 cycle after address.
- rf_rd_data_b  in  DATA_W  read data B; same timing.
- rf_we  out  1  register-file write enable.
- rf_wr_addr  out  REG_AW  write address.
- rf_wr_data  out  DATA_W  write data.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_opcode  out  8  ALU opcode.
- alu_cin  out  1  ALU carry-in.
- alu_c  in  DATA_W  ALU result (combinational).
- alu_flags  in  FLAG_W  ALU flags (combinational).
- psr  out  FLAG_W  latched status flags.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE. All registered outputs are 0: psr, rf_we, rf_wr_*, alu_*, rf_rd_addr_*, done, busy.
  - req_ready=1 once reset_n=1.
  - Reset asserted mid-operation aborts the operation: no write, no psr update, rf_we drops immediately.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture opcode/rdest/rsrc/imm/use_imm, drive rf_rd_addr_a=rdest and rf_rd_addr_b=rsrc, then go to READ.
- READ:
  - Register-file data arrives.
  - Register alu_a=rf_rd_data_a.
  - Register alu_b=rf_rd_data_b, or the extended immediate when use_imm=1.
  - Register alu_opcode=captured opcode and alu_cin=psr[3].
  - Go to EXEC.
- EXEC:
  - ALU settles.
  - Capture alu_c into rf_wr_data and alu_flags into a holding register.
  - Go to WB.
- WB:
  - rf_we=1 for exactly this cycle if the op writes back. rf_wr_addr=rdest.
  - psr<=held flags at the end of the cycle. done=1.
  - req_ready=1. If req_valid, accept the next request and go to READ; otherwise go to IDLE.
- Latency: request accepted at edge N; done high in cycle N+3. Throughput is 1 op per 3 cycles when back-to-back.
- busy=1 in READ, EXEC, WB.
- Immediate extension:
  - Sign-extend req_imm for opcode[7:4] in {0101 ADDI, 0111 ADDCI, 1001 SUBI, 1011 CMPI}.
  - Zero-extend for 0110 ADDUI and for all other opcodes.
- Write-back suppression (done and psr update still occur):
  - CMP (0x0B), CMPU (0x0F), CMPI (opcode[7:4]=1011).
- NOP (opcode 0x00): no write-back, psr unchanged, done still pulses.
- All other opcodes are passed to the ALU unchanged. The result is written back and psr is updated.
- Hazards: a write in WB at edge M is visible to the next op's READ data at edge M+1 or later. No forwarding is needed.
- rdest==rsrc is legal; both read ports carry the same register.
- req_* inputs are ignored while req_ready=0. Inputs are sampled only on the accepting edge; later changes have no effect.

Test Plan:
- Reset, then ADD r1(0x0003)+r2(0x0004) -> rf_we pulse with addr=1, data=0x0007; psr=00000; done exactly 3 cycles after accept.
- ADDC with psr C=1: r1=0xFFFF, r2=0x0001, then ADDC r3(0x0000)+r4(0x0000) -> alu_cin=1, result 0x0001.
- CMPI opcode 0xB0, req_imm=0xFF, use_imm=1, r5=0xFFFF -> alu_b=0xFFFF, rf_we stays 0, psr[4]=1, done pulses.
- ADDUI opcode 0x60, imm=0x80 -> alu_b=0x0080 (zero-extended). ADDI opcode 0x50, imm=0x80 -> alu_b=0xFF80.
- req_valid held high for 4 ops -> accepts in IDLE then every WB; done every 3 cycles; each op reads the previous op's write-back correctly.
- Assert reset_n=0 during EXEC -> rf_we never rises, psr=0, req_ready=1 after release, next op completes normally.
